// File: rtl/param_counter_pkg.sv
// Shared constants and parameter-legality helper for the modulo up/down counter.
package param_counter_pkg;

  localparam int WRAP = 0;
  localparam int SAT  = 1;

  // A modulus is usable when it covers at least two states and fits in WIDTH bits.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/param_counter.sv
// Modulo-MODULUS up/down counter with clear/load, wrap or saturate at the bounds,
// a one-cycle terminal-count pulse and a sticky overflow flag.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_zero,
  output logic             at_max,
  output logic             overflow
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("param_counter: MODULUS must lie in 2..2**WIDTH");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable without truncation.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT = MOD_EXT - 1'b1;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             overflow_next;
  logic             bound_hit;

  assign count_ext = {1'b0, count};
  assign inc_ext   = count_ext + 1'b1;
  assign dec_ext   = count_ext - 1'b1;
  assign at_zero   = (count == '0);
  assign at_max    = (count_ext == MAX_EXT);

  always_comb begin
    count_next    = count;
    tc_next       = 1'b0;
    overflow_next = overflow;
    bound_hit     = 1'b0;
    if (clear) begin
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (load) begin
      // Out-of-range load values clamp to the top of the range.
      if ({1'b0, load_value} < MOD_EXT) count_next = load_value;
      else                              count_next = MAX_EXT[WIDTH-1:0];
    end else if (enable) begin
      if (up) begin
        if (at_max) begin
          bound_hit  = 1'b1;
          count_next = (SATURATE == SAT) ? count : '0;
        end else begin
          count_next = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          bound_hit  = 1'b1;
          count_next = (SATURATE == SAT) ? count : MAX_EXT[WIDTH-1:0];
        end else begin
          count_next = dec_ext[WIDTH-1:0];
        end
      end
    end
    if (bound_hit) begin
      tc_next       = 1'b1;
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count    <= count_next;
      tc       <= tc_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bit width of count, load_value and derived limits.
REQ-002 SHALL have parameter MODULUS, default 16, meaning count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0, meaning 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 SHALL have port clk, input, 1, meaning single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1, meaning count step permitted this cycle.
REQ-007 SHALL have port up, input, 1, meaning direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port clear, input, 1, meaning synchronous clear to zero.
REQ-009 SHALL have port load, input, 1, meaning synchronous load of load_value.
REQ-010 SHALL have port load_value, input, WIDTH, meaning value to load.
REQ-011 SHALL have port count, output, WIDTH, meaning registered count.
REQ-012 SHALL have port tc, output, 1, meaning registered one-cycle pulse on bound crossing (wrap or saturation hit).
REQ-013 SHALL have port at_zero, output, 1, meaning combinational count == 0.
REQ-014 SHALL have port at_max, output, 1, meaning combinational count == MODULUS-1.
REQ-015 SHALL have port overflow, output, 1, meaning sticky flag set on any bound event, cleared only by clear or reset.

Function
REQ-016 SHALL apply per-cycle priority: clear > load > enable step > hold.
REQ-017 SHALL on clear set count=0, tc=0, overflow=0.
REQ-018 SHALL on load set count=load_value if load_value < MODULUS, else MODULUS-1; tc=0; overflow unchanged.
REQ-019 SHALL on enable with up=1 and count < MODULUS-1 increment by 1; with up=0 and count > 0 decrement by 1.
REQ-020 SHALL in wrap mode (SATURATE=0): up at MODULUS-1 -> 0, down at 0 -> MODULUS-1; tc=1 next cycle; overflow set.
REQ-021 SHALL in saturate mode (SATURATE=1): up at MODULUS-1 or down at 0 holds count; tc=1 for each such attempted step; overflow set.
REQ-022 SHALL deassert tc in every cycle without a bound event (tc never held more than one cycle per event).
REQ-023 SHALL ignore up when enable=0; direction change takes effect on the same cycle it is sampled.
REQ-024 SHALL reach count value after one clock edge (latency 1) for clear, load and step.
REQ-025 SHALL never present count >= MODULUS at any time.
REQ-026 SHALL perform arithmetic at WIDTH+1 bits internally so MODULUS = 2**WIDTH wraps without truncation error.

Reset
REQ-027 SHALL on rst=0 immediately set count=0, tc=0, overflow=0, independent of clk.
REQ-028 SHALL resume from count=0 on first rising clk edge after rst release; reset mid-count discards all state.

Structure
REQ-029 SHALL place mode constants (WRAP=0, SAT=1) and a MODULUS legality check function in package param_counter_pkg.
REQ-030 SHALL be a single module; no sub-module, bound logic inline.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-031 SHALL check reset: rst=0 mid-count at 7 -> count=0, tc=0, overflow=0 without clk edge.
REQ-032 SHALL check wrap up: enable=1, up=1 from 0 for 10 cycles -> count 0..9,0; tc pulse exactly once after 9->0; overflow=1.
REQ-033 SHALL check wrap down: load 0, enable=1, up=0 -> count 9 next cycle, tc=1 one cycle.
REQ-034 SHALL check saturate (SATURATE=1): up 12 cycles from 0 -> count holds 9, tc pulses on each of the 3 held steps.
REQ-035 SHALL check priority: clear=1, load=1, load_value=5, enable=1 same cycle -> count=0; load_value=13 alone -> count=9.
REQ-036 SHALL check full range (WIDTH=4, MODULUS=16): up from 15 -> 0, tc=1.
